id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
//  Decode-to-execute pipeline register; sits directly upstream of the ALU.
//  Captures decoded operands and the 4-bit ALU op, selects sources (rs1/PC, rs2/imm),
//  resolves forwarding from MEM/WB, and presents registered in1/in2/op_code to the ALU.
//  Single-entry valid/ready buffer with flush; stalls cleanly under downstream backpressure.
// PARAMETERS
//  DATA_WIDTH     32  operand/PC width
//  OP_CODE_WIDTH  4   ALU op width (ADD=0000 .. SLT=1001)
//  REG_ADDR_WIDTH 5   register index width
// PORTS
//  clk           in   1    sole clock, rising edge
//  rst_n         in   1    asynchronous, active-low reset
//  in_valid      in   1    decode has a valid instruction
//  in_ready      out  1    stage can accept this cycle
//  in_pc         in   DW   instruction PC
//  in_rs1_data   in   DW   regfile read 1
//  in_rs2_data   in   DW   regfile read 2
//  in_imm        in   DW   sign-extended immediate
//  in_rs1_addr   in   RAW  source 1 index
//  in_rs2_addr   in   RAW  source 2 index
//  in_rd_addr    in   RAW  destination index
//  in_alu_op     in   OCW  ALU op code
//  in_src1_sel   in   1    0=rs1, 1=PC
//  in_src2_sel   in   1    0=rs2, 1=imm
//  in_reg_write  in   1    instruction writes rd
//  flush         in   1    kill held and incoming instruction
//  mem_fwd_we/rd/data  in 1/RAW/DW  MEM-stage result bypass
//  wb_fwd_we/rd/data   in 1/RAW/DW  WB-stage result bypass
//  ex_valid      out  1    ALU inputs valid
//  ex_ready      in   1    execute consumes this cycle
//  ex_in1,ex_in2 out  DW   ALU operands
//  ex_op_code    out  OCW  ALU op
//  ex_rd_addr    out  RAW  dest index;  ex_reg_write out 1;  ex_pc out DW
// BEHAVIOUR
//  - Reset (async, rst_n=0): ex_valid=0, all ex_* data/ctrl=0 (op_code 0000); release sync to clk.
//  - in_ready = !ex_valid || ex_ready (combinational); accept when in_valid && in_ready.
//  - Latency 1: accepted beat visible on ex_* next edge; full throughput when ex_ready=1.
//  - Hold: ex_valid && !ex_ready -> ex_* stable except forwarding snoop (below).
//  - Drain: ex_valid && ex_ready && !in_valid -> ex_valid=0 next edge.
//  - Flush: priority over accept; next edge ex_valid=0, ex_reg_write=0; incoming beat dropped.
//  - Operand select at capture: src1 = sel?pc:fwd(rs1); src2 = sel?imm:fwd(rs2).
//  - fwd(x): mem_fwd if mem_fwd_we && rd==x_addr; else wb_fwd likewise; else regfile data.
//    rd==0 never forwards. MEM beats WB when both match.
//  - Snoop while holding: held rs1/rs2 addrs/sels stored; if register-sourced operand matches a
//    live forward (same priority), operand updated that edge.
//  - No arithmetic; widths pass-through; op_code not validated (ALU defaults unknown ops).
// CONFIGURATION
//  ID_EX_FORWARDING_EN defined: forwarding and snoop as above.
//  Undefined: fwd ports ignored, operands taken raw from in_rs*_data; hazards stall upstream.
// STRUCTURE
//  riscv_pkg: alu_op_e enum (ADD..SLT codes), src1_sel_e/src2_sel_e, XLEN, REG_ADDR_WIDTH.
//  Sub-module operand_fwd_mux: one instance per operand (addr, raw data, 2 bypass sources).
// TESTING
//  1 rs1=5 rs2=7 op=0000, ex_ready=1 -> next cycle ex_in1=5 ex_in2=7 op=0000 ex_valid=1.
//  2 ex_ready=0 two beats -> in_ready=0, first held stable; second on cycle after ex_ready=1.
//  3 rs1_addr=3, mem rd=3 0xAA, wb rd=3 0xBB -> ex_in1=0xAA; rs addr 0 with rd=0 -> raw data.
//  4 src1=PC pc=0x100, src2=imm 0xFFFFFFFC -> ex_in1=0x100 ex_in2=0xFFFFFFFC despite fwd hits.
//  5 flush with in_valid=1 and held beat -> ex_valid=0, ex_reg_write=0 next edge.
//  6 held rs2_addr=4, wb rd=4 0x55 during stall -> ex_in2=0x55; rst_n=0 mid-stall -> all 0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared types and widths for the decode/execute boundary.
package riscv_pkg;

    localparam int unsigned XLEN           = 32;
    localparam int unsigned REG_ADDR_WIDTH = 5;
    localparam int unsigned ALU_OP_WIDTH   = 4;

    // ALU operation encodings; codes above SLT are passed through untouched
    typedef enum logic [ALU_OP_WIDTH-1:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_AND  = 4'b0010,
        ALU_OR   = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SLL  = 4'b0101,
        ALU_SRL  = 4'b0110,
        ALU_SRA  = 4'b0111,
        ALU_SLTU = 4'b1000,
        ALU_SLT  = 4'b1001
    } alu_op_e;

    typedef enum logic {
        SRC1_RS1 = 1'b0,
        SRC1_PC  = 1'b1
    } src1_sel_e;

    typedef enum logic {
        SRC2_RS2 = 1'b0,
        SRC2_IMM = 1'b1
    } src2_sel_e;

endpackage

// File: rtl/operand_fwd_mux.sv
// Per-operand bypass select: MEM result beats WB result beats raw data.
// Register x0 never takes a bypass.
module operand_fwd_mux
    import riscv_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = XLEN,
    parameter int unsigned REG_ADDR_WIDTH = riscv_pkg::REG_ADDR_WIDTH
) (
    input  logic [REG_ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0]     raw_i,
    input  logic                      mem_we_i,
    input  logic [REG_ADDR_WIDTH-1:0] mem_rd_i,
    input  logic [DATA_WIDTH-1:0]     mem_data_i,
    input  logic                      wb_we_i,
    input  logic [REG_ADDR_WIDTH-1:0] wb_rd_i,
    input  logic [DATA_WIDTH-1:0]     wb_data_i,
    output logic [DATA_WIDTH-1:0]     data_o
);

    // Priority bypass selection
    always_comb begin
        data_o = raw_i;
        if (addr_i != '0) begin
            if (mem_we_i && (mem_rd_i == addr_i)) begin
                data_o = mem_data_i;
            end else if (wb_we_i && (wb_rd_i == addr_i)) begin
                data_o = wb_data_i;
            end
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// Decode-to-execute pipeline register feeding the ALU.
// Single-entry valid/ready buffer with flush, operand source select and
// MEM/WB bypass. Define ID_EX_FORWARDING_EN to enable bypass and the
// held-operand snoop; otherwise operands come straight from the regfile.
module id_ex_stage
    import riscv_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = XLEN,
    parameter int unsigned OP_CODE_WIDTH  = ALU_OP_WIDTH,
    parameter int unsigned REG_ADDR_WIDTH = riscv_pkg::REG_ADDR_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_WIDTH-1:0]     in_pc,
    input  logic [DATA_WIDTH-1:0]     in_rs1_data,
    input  logic [DATA_WIDTH-1:0]     in_rs2_data,
    input  logic [DATA_WIDTH-1:0]     in_imm,
    input  logic [REG_ADDR_WIDTH-1:0] in_rs1_addr,
    input  logic [REG_ADDR_WIDTH-1:0] in_rs2_addr,
    input  logic [REG_ADDR_WIDTH-1:0] in_rd_addr,
    input  logic [OP_CODE_WIDTH-1:0]  in_alu_op,
    input  logic                      in_src1_sel,
    input  logic                      in_src2_sel,
    input  logic                      in_reg_write,
    input  logic                      flush,
    input  logic                      mem_fwd_we,
    input  logic [REG_ADDR_WIDTH-1:0] mem_fwd_rd,
    input  logic [DATA_WIDTH-1:0]     mem_fwd_data,
    input  logic                      wb_fwd_we,
    input  logic [REG_ADDR_WIDTH-1:0] wb_fwd_rd,
    input  logic [DATA_WIDTH-1:0]     wb_fwd_data,
    output logic                      ex_valid,
    input  logic                      ex_ready,
    output logic [DATA_WIDTH-1:0]     ex_in1,
    output logic [DATA_WIDTH-1:0]     ex_in2,
    output logic [OP_CODE_WIDTH-1:0]  ex_op_code,
    output logic [REG_ADDR_WIDTH-1:0] ex_rd_addr,
    output logic                      ex_reg_write,
    output logic [DATA_WIDTH-1:0]     ex_pc
);

    logic                      valid_q, valid_d;
    logic [DATA_WIDTH-1:0]     in1_q, in1_d;
    logic [DATA_WIDTH-1:0]     in2_q, in2_d;
    logic [OP_CODE_WIDTH-1:0]  op_q, op_d;
    logic [REG_ADDR_WIDTH-1:0] rd_q, rd_d;
    logic                      rw_q, rw_d;
    logic [DATA_WIDTH-1:0]     pc_q, pc_d;
    logic [REG_ADDR_WIDTH-1:0] rs1_addr_q, rs1_addr_d;
    logic [REG_ADDR_WIDTH-1:0] rs2_addr_q, rs2_addr_d;
    logic                      sel1_q, sel1_d;
    logic                      sel2_q, sel2_d;

    logic                      hold;
    logic                      accept;
    logic                      mem_we_eff;
    logic                      wb_we_eff;
    logic [REG_ADDR_WIDTH-1:0] op1_addr, op2_addr;
    logic [DATA_WIDTH-1:0]     op1_raw, op2_raw;
    logic [DATA_WIDTH-1:0]     op1_fwd, op2_fwd;

    assign in_ready = !valid_q || ex_ready;
    assign accept   = in_valid && in_ready;
    assign hold     = valid_q && !ex_ready;

`ifdef ID_EX_FORWARDING_EN
    assign mem_we_eff = mem_fwd_we;
    assign wb_we_eff  = wb_fwd_we;
`else
    assign mem_we_eff = 1'b0;
    assign wb_we_eff  = 1'b0;
    logic unused_fwd;
    assign unused_fwd = mem_fwd_we ^ wb_fwd_we;
`endif

    // While holding, the bypass muxes look at the stored source index and
    // the held operand, so a miss simply recirculates the held value.
    assign op1_addr = hold ? rs1_addr_q : in_rs1_addr;
    assign op1_raw  = hold ? in1_q      : in_rs1_data;
    assign op2_addr = hold ? rs2_addr_q : in_rs2_addr;
    assign op2_raw  = hold ? in2_q      : in_rs2_data;

    operand_fwd_mux #(
        .DATA_WIDTH    (DATA_WIDTH),
        .REG_ADDR_WIDTH(REG_ADDR_WIDTH)
    ) u_fwd_rs1 (
        .addr_i    (op1_addr),
        .raw_i     (op1_raw),
        .mem_we_i  (mem_we_eff),
        .mem_rd_i  (mem_fwd_rd),
        .mem_data_i(mem_fwd_data),
        .wb_we_i   (wb_we_eff),
        .wb_rd_i   (wb_fwd_rd),
        .wb_data_i (wb_fwd_data),
        .data_o    (op1_fwd)
    );

    operand_fwd_mux #(
        .DATA_WIDTH    (DATA_WIDTH),
        .REG_ADDR_WIDTH(REG_ADDR_WIDTH)
    ) u_fwd_rs2 (
        .addr_i    (op2_addr),
        .raw_i     (op2_raw),
        .mem_we_i  (mem_we_eff),
        .mem_rd_i  (mem_fwd_rd),
        .mem_data_i(mem_fwd_data),
        .wb_we_i   (wb_we_eff),
        .wb_rd_i   (wb_fwd_rd),
        .wb_data_i (wb_fwd_data),
        .data_o    (op2_fwd)
    );

    // Next-state: flush > accept > hold (snoop) > drain
    always_comb begin
        valid_d    = valid_q;
        in1_d      = in1_q;
        in2_d      = in2_q;
        op_d       = op_q;
        rd_d       = rd_q;
        rw_d       = rw_q;
        pc_d       = pc_q;
        rs1_addr_d = rs1_addr_q;
        rs2_addr_d = rs2_addr_q;
        sel1_d     = sel1_q;
        sel2_d     = sel2_q;
        if (flush) begin
            valid_d = 1'b0;
            rw_d    = 1'b0;
        end else if (accept) begin
            valid_d    = 1'b1;
            in1_d      = (in_src1_sel == SRC1_PC)  ? in_pc  : op1_fwd;
            in2_d      = (in_src2_sel == SRC2_IMM) ? in_imm : op2_fwd;
            op_d       = in_alu_op;
            rd_d       = in_rd_addr;
            rw_d       = in_reg_write;
            pc_d       = in_pc;
            rs1_addr_d = in_rs1_addr;
            rs2_addr_d = in_rs2_addr;
            sel1_d     = in_src1_sel;
            sel2_d     = in_src2_sel;
        end else if (hold) begin
            if (sel1_q == SRC1_RS1) begin
                in1_d = op1_fwd;
            end
            if (sel2_q == SRC2_RS2) begin
                in2_d = op2_fwd;
            end
        end else begin
            valid_d = 1'b0;
        end
    end

    // Pipeline register state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= 1'b0;
            in1_q      <= '0;
            in2_q      <= '0;
            op_q       <= '0;
            rd_q       <= '0;
            rw_q       <= 1'b0;
            pc_q       <= '0;
            rs1_addr_q <= '0;
            rs2_addr_q <= '0;
            sel1_q     <= 1'b0;
            sel2_q     <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            in1_q      <= in1_d;
            in2_q      <= in2_d;
            op_q       <= op_d;
            rd_q       <= rd_d;
            rw_q       <= rw_d;
            pc_q       <= pc_d;
            rs1_addr_q <= rs1_addr_d;
            rs2_addr_q <= rs2_addr_d;
            sel1_q     <= sel1_d;
            sel2_q     <= sel2_d;
        end
    end

    assign ex_valid     = valid_q;
    assign ex_in1       = in1_q;
    assign ex_in2       = in2_q;
    assign ex_op_code   = op_q;
    assign ex_rd_addr   = rd_q;
    assign ex_reg_write = rw_q;
    assign ex_pc        = pc_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage. Bypass expectations follow
// ID_EX_FORWARDING_EN so the same bench covers both builds.
module tb_id_ex_stage;

    localparam int unsigned DW  = 32;
    localparam int unsigned OCW = 4;
    localparam int unsigned RAW = 5;

`ifdef ID_EX_FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic           clk;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [DW-1:0]  in_pc, in_rs1_data, in_rs2_data, in_imm;
    logic [RAW-1:0] in_rs1_addr, in_rs2_addr, in_rd_addr;
    logic [OCW-1:0] in_alu_op;
    logic           in_src1_sel, in_src2_sel, in_reg_write;
    logic           flush;
    logic           mem_fwd_we, wb_fwd_we;
    logic [RAW-1:0] mem_fwd_rd, wb_fwd_rd;
    logic [DW-1:0]  mem_fwd_data, wb_fwd_data;
    logic           ex_valid, ex_ready;
    logic [DW-1:0]  ex_in1, ex_in2, ex_pc;
    logic [OCW-1:0] ex_op_code;
    logic [RAW-1:0] ex_rd_addr;
    logic           ex_reg_write;

    int unsigned checks = 0;
    int unsigned errors = 0;

    id_ex_stage #(
        .DATA_WIDTH    (DW),
        .OP_CODE_WIDTH (OCW),
        .REG_ADDR_WIDTH(RAW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_pc       (in_pc),
        .in_rs1_data (in_rs1_data),
        .in_rs2_data (in_rs2_data),
        .in_imm      (in_imm),
        .in_rs1_addr (in_rs1_addr),
        .in_rs2_addr (in_rs2_addr),
        .in_rd_addr  (in_rd_addr),
        .in_alu_op   (in_alu_op),
        .in_src1_sel (in_src1_sel),
        .in_src2_sel (in_src2_sel),
        .in_reg_write(in_reg_write),
        .flush       (flush),
        .mem_fwd_we  (mem_fwd_we),
        .mem_fwd_rd  (mem_fwd_rd),
        .mem_fwd_data(mem_fwd_data),
        .wb_fwd_we   (wb_fwd_we),
        .wb_fwd_rd   (wb_fwd_rd),
        .wb_fwd_data (wb_fwd_data),
        .ex_valid    (ex_valid),
        .ex_ready    (ex_ready),
        .ex_in1      (ex_in1),
        .ex_in2      (ex_in2),
        .ex_op_code  (ex_op_code),
        .ex_rd_addr  (ex_rd_addr),
        .ex_reg_write(ex_reg_write),
        .ex_pc       (ex_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive_beat(input logic [DW-1:0] pc, input logic [RAW-1:0] a1, input logic [DW-1:0] d1,
                              input logic [RAW-1:0] a2, input logic [DW-1:0] d2, input logic [DW-1:0] imm,
                              input logic [RAW-1:0] rd, input logic [OCW-1:0] op,
                              input logic s1, input logic s2, input logic rw);
        in_valid     = 1'b1;
        in_pc        = pc;
        in_rs1_addr  = a1;
        in_rs1_data  = d1;
        in_rs2_addr  = a2;
        in_rs2_data  = d2;
        in_imm       = imm;
        in_rd_addr   = rd;
        in_alu_op    = op;
        in_src1_sel  = s1;
        in_src2_sel  = s2;
        in_reg_write = rw;
    endtask

    task automatic set_fwd(input logic mwe, input logic [RAW-1:0] mrd, input logic [DW-1:0] md,
                           input logic wwe, input logic [RAW-1:0] wrd, input logic [DW-1:0] wd);
        mem_fwd_we   = mwe;
        mem_fwd_rd   = mrd;
        mem_fwd_data = md;
        wb_fwd_we    = wwe;
        wb_fwd_rd    = wrd;
        wb_fwd_data  = wd;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n    = 1'b0;
        flush    = 1'b0;
        ex_ready = 1'b1;
        drive_beat('0, '0, '0, '0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b0;
        set_fwd(1'b0, '0, '0, 1'b0, '0, '0);

        // Reset state
        #12;
        check_eq("rst_valid", ex_valid, 0);
        check_eq("rst_in1", ex_in1, 0);
        check_eq("rst_in2", ex_in2, 0);
        check_eq("rst_op", ex_op_code, 0);
        check_eq("rst_rw", ex_reg_write, 0);
        check_eq("rst_ready", in_ready, 1);
        rst_n = 1'b1;

        // 1: basic capture, one-cycle latency, then drain
        drive_beat(32'h10, 5'd1, 32'd5, 5'd2, 32'd7, 32'h0, 5'd3, 4'b0000, 1'b0, 1'b0, 1'b1);
        step();
        check_eq("t1_valid", ex_valid, 1);
        check_eq("t1_in1", ex_in1, 5);
        check_eq("t1_in2", ex_in2, 7);
        check_eq("t1_op", ex_op_code, 0);
        check_eq("t1_rd", ex_rd_addr, 3);
        check_eq("t1_pc", ex_pc, 32'h10);
        in_valid = 1'b0;
        step();
        check_eq("t1_drain", ex_valid, 0);

        // 2: backpressure holds first beat, second enters after release
        ex_ready = 1'b0;
        drive_beat(32'h20, 5'd1, 32'h11, 5'd2, 32'h22, 32'h0, 5'd4, 4'b0001, 1'b0, 1'b0, 1'b1);
        step();
        check_eq("t2_a_in1", ex_in1, 32'h11);
        check_eq("t2_ready_lo", in_ready, 0);
        drive_beat(32'h24, 5'd1, 32'h33, 5'd2, 32'h44, 32'h0, 5'd5, 4'b0010, 1'b0, 1'b0, 1'b1);
        step();
        check_eq("t2_hold_in1", ex_in1, 32'h11);
        check_eq("t2_hold_in2", ex_in2, 32'h22);
        check_eq("t2_hold_op", ex_op_code, 1);
        step();
        check_eq("t2_hold2_rd", ex_rd_addr, 4);
        check_eq("t2_hold2_valid", ex_valid, 1);
        ex_ready = 1'b1;
        #1;
        check_eq("t2_ready_hi", in_ready, 1);
        step();
        check_eq("t2_b_in1", ex_in1, 32'h33);
        check_eq("t2_b_in2", ex_in2, 32'h44);
        check_eq("t2_b_op", ex_op_code, 2);
        in_valid = 1'b0;
        step();

        // 3: MEM beats WB; x0 never bypasses; WB-only hit
        set_fwd(1'b1, 5'd3, 32'hAA, 1'b1, 5'd3, 32'hBB);
        drive_beat(32'h30, 5'd3, 32'h1, 5'd9, 32'h9, 32'h0, 5'd6, 4'b0000, 1'b0, 1'b0, 1'b1);
        step();
        check_eq("t3_mem_prio", ex_in1, FWD ? 32'hAA : 32'h1);
        check_eq("t3_nomatch", ex_in2, 32'h9);
        set_fwd(1'b1, 5'd0, 32'hAA, 1'b1, 5'd6, 32'hCC);
        drive_beat(32'h34, 5'd0, 32'h99, 5'd6, 32'h66, 32'h0, 5'd6, 4'b0000, 1'b0, 1'b0, 1'b1);
        step();
        check_eq("t3_x0_raw", ex_in1, 32'h99);
        check_eq("t3_wb_fwd", ex_in2, FWD ? 32'hCC : 32'h66);

        // 4: PC / immediate sources ignore bypass hits
        set_fwd(1'b1, 5'd3, 32'hAA, 1'b1, 5'd3, 32'hBB);
        drive_beat(32'h100, 5'd3, 32'h1, 5'd3, 32'h2, 32'hFFFF_FFFC, 5'd7, 4'b0000, 1'b1, 1'b1, 1'b1);
        step();
        check_eq("t4_pc_src", ex_in1, 32'h100);
        check_eq("t4_imm_src", ex_in2, 32'hFFFF_FFFC);
        set_fwd(1'b0, '0, '0, 1'b0, '0, '0);
        in_valid = 1'b0;
        step();

        // 5: flush kills held and incoming beats
        ex_ready = 1'b0;
        drive_beat(32'h40, 5'd1, 32'h1, 5'd2, 32'h2, 32'h0, 5'd8, 4'b0011, 1'b0, 1'b0, 1'b1);
        step();
        check_eq("t5_held", ex_valid, 1);
        drive_beat(32'h44, 5'd1, 32'h3, 5'd2, 32'h4, 32'h0, 5'd9, 4'b0100, 1'b0, 1'b0, 1'b1);
        flush = 1'b1;
        step();
        check_eq("t5_flush_valid", ex_valid, 0);
        check_eq("t5_flush_rw", ex_reg_write, 0);
        flush    = 1'b0;
        in_valid = 1'b0;
        step();
        check_eq("t5_dropped", ex_valid, 0);

        // 6: snoop on held register operand, then async reset mid-stall
        drive_beat(32'h200, 5'd1, 32'h5, 5'd4, 32'h44, 32'h0, 5'd7, 4'b1001, 1'b0, 1'b0, 1'b1);
        step();
        check_eq("t6_held_in2", ex_in2, 32'h44);
        in_valid = 1'b0;
        set_fwd(1'b0, '0, '0, 1'b1, 5'd4, 32'h55);
        step();
        check_eq("t6_snoop_in2", ex_in2, FWD ? 32'h55 : 32'h44);
        check_eq("t6_snoop_in1", ex_in1, 32'h5);
        check_eq("t6_snoop_valid", ex_valid, 1);
        check_eq("t6_snoop_op", ex_op_code, 9);
        set_fwd(1'b0, '0, '0, 1'b0, '0, '0);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t6_rst_valid", ex_valid, 0);
        check_eq("t6_rst_in1", ex_in1, 0);
        check_eq("t6_rst_in2", ex_in2, 0);
        check_eq("t6_rst_op", ex_op_code, 0);
        check_eq("t6_rst_rd", ex_rd_addr, 0);
        check_eq("t6_rst_rw", ex_reg_write, 0);
        check_eq("t6_rst_pc", ex_pc, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check_eq("t6_post_rst", ex_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
